// File: rtl/row_scan_sequencer_pkg.sv
// row_scan_sequencer_pkg: shared state encoding and address width for the row scan sequencer
package row_scan_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BLANK = 2'd1, ST_DWELL = 2'd2} state_e;
  localparam int SEL_W = 3;
endpackage

// File: rtl/row_scan_sequencer_scan_timer.sv
// scan_timer: loadable down-counter with a registered flag marking the final count
module scan_timer
  import row_scan_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         last
);
  logic [W-1:0] count_q;
  logic         last_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      count_q <= load_val;
      last_q  <= load_val == W'(1);
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
      last_q  <= count_q == W'(2);
    end
  end
  assign count = count_q;
  assign last  = last_q;
endmodule

// File: rtl/row_scan_sequencer.sv
// row_scan_sequencer: steps a 3-to-8 decoder through its rows with blanking gaps between dwells
module row_scan_sequencer
  import row_scan_sequencer_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int NUM_ROWS     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               busy,
  output logic               row_done,
  output logic               frame_done
);
  localparam logic [SEL_W-1:0]   LAST_ROW = SEL_W'(NUM_ROWS - 1);
  localparam logic [DWELL_W-1:0] BLANK_LD = DWELL_W'(BLANK_CYCLES);
  state_e             st_q;
  logic [SEL_W-1:0]   sel_q;
  logic               cont_q, sel_en_q, busy_q, row_done_q, frame_done_q;
  logic [DWELL_W-1:0] dwell_eff, cnt, ld_val_d;
  logic               ld_d, last, wrap_end;
  scan_timer #(.W(DWELL_W)) u_timer (
    .clk(clk), .reset(reset), .load(ld_d), .load_val(ld_val_d), .count(cnt), .last(last)
  );
  always_comb begin
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    wrap_end  = st_q == ST_DWELL && sel_q == LAST_ROW && !cont_q;
    ld_d      = !stop && ((st_q == ST_IDLE && start) ||
                ((st_q == ST_BLANK || st_q == ST_DWELL) && last && !wrap_end));
    ld_val_d  = (st_q == ST_BLANK) ? dwell_eff : BLANK_LD;
  end
  // Pulses are set one cycle early so they line up with the final dwell count.
  always_ff @(posedge clk) begin
    if (reset || stop) begin
      st_q         <= ST_IDLE;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (reset) cont_q <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: if (start) begin
          st_q   <= ST_BLANK;
          cont_q <= continuous;
          busy_q <= 1'b1;
        end
        ST_BLANK: if (last) begin
          st_q         <= ST_DWELL;
          sel_en_q     <= 1'b1;
          row_done_q   <= dwell_eff == DWELL_W'(1);
          frame_done_q <= dwell_eff == DWELL_W'(1) && sel_q == LAST_ROW;
        end
        ST_DWELL: begin
          row_done_q   <= cnt == DWELL_W'(2);
          frame_done_q <= cnt == DWELL_W'(2) && sel_q == LAST_ROW;
          if (last) begin
            sel_en_q <= 1'b0;
            sel_q    <= (sel_q == LAST_ROW) ? '0 : sel_q + SEL_W'(1);
            st_q     <= wrap_end ? ST_IDLE : ST_BLANK;
            busy_q   <= !wrap_end;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end
  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign busy       = busy_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_row_scan_sequencer.sv
// tb_row_scan_sequencer: scoreboard bench; row_done pulses are matched against queued expectations
module tb_row_scan_sequencer;
  typedef struct {
    logic [2:0] sel;
    logic       fd;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, stop, continuous;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_en, busy, row_done, frame_done;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         t0, t1;
  exp_t       q[$];
  logic [2:0] prev_sel;
  logic       prev_rd, prev_fd, armed = 1'b0;

  row_scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(2), .NUM_ROWS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .sel(sel), .sel_en(sel_en), .busy(busy), .row_done(row_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cyc=%0d)", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int r, input int c, input bit fd);
    exp_t e;
    e.sel = 3'(r);
    e.fd  = fd;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (row_done) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_row_done @cyc %0d: sel=%0d frame_done=%0b, none expected", cyc, sel, frame_done);
      end else begin
        e = q.pop_front();
        if (sel !== e.sel || frame_done !== e.fd || cyc != e.cyc) begin
          n_err++;
          $display("FAIL row_done: got sel=%0d fd=%0b cyc=%0d expected sel=%0d fd=%0b cyc=%0d",
                   sel, frame_done, cyc, e.sel, e.fd, e.cyc);
        end
      end
    end else if (frame_done) begin
      n_err++;
      $display("FAIL frame_without_row @cyc %0d: frame_done=1 row_done=0", cyc);
    end
    if (armed && !reset) begin
      if (sel_en && sel !== prev_sel) begin
        n_err++;
        $display("FAIL sel_moved_while_enabled @cyc %0d: sel %0d -> %0d", cyc, prev_sel, sel);
      end
      if (sel > 3'd7) begin
        n_err++;
        $display("FAIL sel_range @cyc %0d: sel=%0d", cyc, sel);
      end
      if ((row_done && prev_rd) || (frame_done && prev_fd)) begin
        n_err++;
        $display("FAIL pulse_width @cyc %0d: row_done=%0b frame_done=%0b held", cyc, row_done, frame_done);
      end
    end
    prev_sel = sel;
    prev_rd  = row_done;
    prev_fd  = frame_done;
  end

  initial begin
    reset = 1'b1; start = 1'b1; stop = 1'b0; continuous = 1'b0; dwell = 8'd0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {sel, sel_en, busy, row_done, frame_done}, 0);
    end
    reset = 1'b0; start = 1'b0; armed = 1'b1;
    @(negedge clk);

    // one-shot frame, dwell 3
    dwell = 8'd3; continuous = 1'b0; start = 1'b1; t0 = cyc;
    for (int r = 0; r < 8; r++) push(r, t0 + 5 * (r + 1), r == 7);
    @(negedge clk); start = 1'b0;
    wait_to(t0 + 2); chk("blank_gap_first", sel_en, 0);
    wait_to(t0 + 3); chk("first_sel_en", {sel, sel_en}, {3'd0, 1'b1});
    wait_to(t0 + 40); chk("busy_last_row", busy, 1);
    wait_to(t0 + 41); chk("idle_after_frame", {sel, sel_en, busy}, 0);

    // continuous, dwell 1, three frames then stop
    dwell = 8'd1; continuous = 1'b1; start = 1'b1; t0 = cyc;
    for (int k = 0; k < 24; k++) push(k % 8, t0 + 3 * (k + 1), (k % 8) == 7);
    @(negedge clk); start = 1'b0; continuous = 1'b0;
    wait_to(t0 + 25); chk("wrap_blank", {sel, sel_en}, 0);
    wait_to(t0 + 27); chk("wrap_row0", {sel, sel_en}, {3'd0, 1'b1});
    wait_to(t0 + 72); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_after_frames", {sel, sel_en, busy, row_done, frame_done}, 0);

    // stop during row 4 dwell, restart one cycle later
    dwell = 8'd3; start = 1'b1; t0 = cyc;
    for (int r = 0; r < 4; r++) push(r, t0 + 5 * (r + 1), 1'b0);
    @(negedge clk); start = 1'b0;
    wait_to(t0 + 24); chk("row4_dwell", {sel, sel_en}, {3'd4, 1'b1});
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_mid_row", {sel, sel_en, busy, row_done, frame_done}, 0);
    start = 1'b1; t1 = cyc;
    for (int r = 0; r < 8; r++) push(r, t1 + 5 * (r + 1), r == 7);
    @(negedge clk); start = 1'b0;
    wait_to(t1 + 3); chk("restart_row0", {sel, sel_en}, {3'd0, 1'b1});
    wait_to(t1 + 41); chk("restart_idle", busy, 0);

    // start+stop together, ignored start, mid-row dwell change
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("start_stop_same", {sel, sel_en, busy}, 0);
    @(negedge clk); chk("start_stop_stays", busy, 0);
    dwell = 8'd5; start = 1'b1; t0 = cyc;
    for (int r = 0; r < 3; r++) push(r, t0 + 7 * (r + 1), 1'b0);
    for (int r = 3; r < 8; r++) push(r, t0 + 25 + 4 * (r - 3), r == 7);
    @(negedge clk); start = 1'b0;
    wait_to(t0 + 10); start = 1'b1; continuous = 1'b1;
    @(negedge clk); start = 1'b0; continuous = 1'b0;
    wait_to(t0 + 18); dwell = 8'd2;
    wait_to(t0 + 42); chk("oneshot_latched", busy, 0);

    // dwell 0 behaves as 1
    dwell = 8'd0; start = 1'b1; t0 = cyc;
    for (int r = 0; r < 8; r++) push(r, t0 + 3 * (r + 1), r == 7);
    @(negedge clk); start = 1'b0;
    wait_to(t0 + 25); chk("dwell0_idle", busy, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
